// File: rtl/spi_ip_crc_pkg.sv
// Shared definitions for the CRC engine: size encodings, FSM state type and
// the helpers that turn a size code into a bit mask or a top-bit position.
package spi_ip_crc_pkg;

  // CRC width selector; the spare code behaves as a 32-bit CRC.
  typedef enum logic [1:0] {
    CRC_SIZE_8      = 2'b00,
    CRC_SIZE_16     = 2'b01,
    CRC_SIZE_32     = 2'b10,
    CRC_SIZE_32_ALT = 2'b11
  } crc_size_e;

  // Engine control states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } crc_state_e;

  // Mask that keeps only the low N bits of a CRC value for the given size.
  function automatic logic [31:0] crc_mask(input logic [1:0] size);
    case (size)
      CRC_SIZE_8:  return 32'h0000_00FF;
      CRC_SIZE_16: return 32'h0000_FFFF;
      default:     return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Bit N-1 of the CRC register, i.e. the bit that is shifted out next.
  function automatic logic crc_top_bit(input logic [31:0] crc, input logic [1:0] size);
    case (size)
      CRC_SIZE_8:  return crc[7];
      CRC_SIZE_16: return crc[15];
      default:     return crc[31];
    endcase
  endfunction

endpackage

// File: rtl/spi_ip_crc_step.sv
// One serial CRC step: folds a single data bit into an N-bit CRC value.
// Several of these are chained to process more than one bit per clock.
module spi_ip_crc_step
  import spi_ip_crc_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [31:0] poly,
  input  logic [1:0]  size,
  input  logic        data_bit,
  output logic [31:0] crc_next
);

  logic feedback;

  // Feedback is the incoming bit against the bit leaving the register.
  assign feedback = data_bit ^ crc_top_bit(crc, size);

  // Shift, conditionally apply the polynomial, then drop bits above N-1 so
  // unused high polynomial bits never leak into the result.
  assign crc_next = ({crc[30:0], 1'b0} ^ (poly & {32{feedback}})) & crc_mask(size);

endmodule

// File: rtl/spi_ip_crc_engine.sv
// Configurable CRC-8/16/32 engine with a valid/ready word interface.
// A word is captured in IDLE, then consumed PARAM_BITS_PER_CYCLE bits per
// clock in SHIFT; a one-cycle done pulse marks the first IDLE cycle after.
module spi_ip_crc_engine
  import spi_ip_crc_pkg::*;
#(
  parameter int          PARAM_DATA_W         = 8,
  parameter int          PARAM_BITS_PER_CYCLE = 1,
  parameter logic [31:0] PARAM_CRC_INIT       = 32'h0000_0000
) (
  input  logic                    cs_clk_i,
  input  logic                    cs_rst_n_i,
  input  logic [1:0]              cs_crc_size_i,
  input  logic [31:0]             cs_crc_poly_i,
  input  logic [31:0]             cs_crc_seed_i,
  input  logic                    cs_crc_lsb_first_i,
  input  logic                    cs_crc_init_i,
  input  logic [PARAM_DATA_W-1:0] cs_data_i,
  input  logic                    cs_data_valid_i,
  output logic                    cs_data_ready_o,
  input  logic [31:0]             cs_crc_expected_i,
  output logic [31:0]             cs_crc_out_o,
  output logic                    cs_crc_busy_o,
  output logic                    cs_crc_done_o,
  output logic                    cs_crc_match_o
);

  localparam int NUM_CYCLES = PARAM_DATA_W / PARAM_BITS_PER_CYCLE;
  localparam int CNT_W      = (NUM_CYCLES > 1) ? $clog2(NUM_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CYCLES - 1);

  crc_state_e                state;
  logic [31:0]               crc_q;
  logic [PARAM_DATA_W-1:0]   data_sh;
  logic [1:0]                size_sh;
  logic [31:0]               poly_sh;
  logic                      lsb_sh;
  logic [CNT_W-1:0]          cnt;
  logic                      done_q;
  logic                      match_q;

  logic [PARAM_BITS_PER_CYCLE-1:0] step_bits;
  logic [31:0]                     crc_step_out;
  logic                            transfer;

  // Init blocks acceptance so it always wins over a simultaneous word.
  assign cs_data_ready_o = (state == ST_IDLE) && !cs_crc_init_i;
  assign transfer        = cs_data_valid_i && cs_data_ready_o;

  // Pick the bits consumed this cycle, in processing order; the shadow word
  // is shifted every SHIFT cycle so the next bits are always at the edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    step_bits = '0;
    for (int j = 0; j < PARAM_BITS_PER_CYCLE; j++) begin
      step_bits[j] = lsb_sh ? data_sh[j] : data_sh[PARAM_DATA_W-1-j];
    end
  end

  // Chain of single-bit steps; stage g feeds stage g+1 within one clock.
  for (genvar g = 0; g < PARAM_BITS_PER_CYCLE; g++) begin : g_step
    logic [31:0] crc_in;
    logic [31:0] crc_out;

    if (g == 0) begin : g_first
      assign crc_in = crc_q;
    end else begin : g_next
      assign crc_in = g_step[g-1].crc_out;
    end

    spi_ip_crc_step u_step (
      .crc      (crc_in),
      .poly     (poly_sh),
      .size     (size_sh),
      .data_bit (step_bits[g]),
      .crc_next (crc_out)
    );
  end

  assign crc_step_out = g_step[PARAM_BITS_PER_CYCLE-1].crc_out;

  // Control FSM, CRC register, shadow configuration and status flags.
  always_ff @(posedge cs_clk_i or negedge cs_rst_n_i) begin
    if (!cs_rst_n_i) begin
      state   <= ST_IDLE;
      crc_q   <= PARAM_CRC_INIT;
      data_sh <= '0;
      size_sh <= CRC_SIZE_8;
      poly_sh <= '0;
      lsb_sh  <= 1'b0;
      cnt     <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees
      // the pre-edge value of every other register regardless of order.
      done_q <= 1'b0;
      if (cs_crc_init_i) begin
        // Re-seed and abandon any word in flight without a done pulse.
        state   <= ST_IDLE;
        crc_q   <= cs_crc_seed_i & crc_mask(cs_crc_size_i);
        cnt     <= '0;
        match_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (transfer) begin
              data_sh <= cs_data_i;
              size_sh <= cs_crc_size_i;
              poly_sh <= cs_crc_poly_i;
              lsb_sh  <= cs_crc_lsb_first_i;
              cnt     <= '0;
              state   <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            crc_q   <= crc_step_out;
            data_sh <= lsb_sh ? (data_sh >> PARAM_BITS_PER_CYCLE)
                              : (data_sh << PARAM_BITS_PER_CYCLE);
            if (cnt == CNT_LAST) begin
              // Flags land together with the final CRC in the first IDLE cycle.
              state   <= ST_IDLE;
              cnt     <= '0;
              done_q  <= 1'b1;
              match_q <= (crc_step_out == (cs_crc_expected_i & crc_mask(size_sh)));
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cs_crc_out_o   = crc_q;
  assign cs_crc_busy_o  = (state == ST_SHIFT);
  assign cs_crc_done_o  = done_q;
  assign cs_crc_match_o = match_q;

endmodule
